// File: rtl/hdmi_pll_seq_if.sv
// Control and status bundle of the HDMI PLL sequencer.
// slave is the sequencer side, master the PLL/system side.
interface hdmi_pll_seq_if #(
    parameter int RW = 2
);
    logic          pll_locked;
    logic          restart;
    logic          pll_rst;
    logic          clk_ready;
    logic          fault;
    logic [2:0]    state;
    logic [RW-1:0] retry_cnt;
    logic [7:0]    lock_loss_cnt;

    modport master (
        output pll_locked,
        output restart,
        input  pll_rst,
        input  clk_ready,
        input  fault,
        input  state,
        input  retry_cnt,
        input  lock_loss_cnt
    );

    modport slave (
        input  pll_locked,
        input  restart,
        output pll_rst,
        output clk_ready,
        output fault,
        output state,
        output retry_cnt,
        output lock_loss_cnt
    );
endinterface

// File: rtl/hdmi_pll_seq.sv
// HDMI PLL power-up, lock qualification and recovery sequencer.
// Runs on refclk; outputs decode the registered state only.
module hdmi_pll_seq #(
    parameter int RST_CYCLES     = 40,
    parameter int STABLE_CYCLES  = 4000,
    parameter int TIMEOUT_CYCLES = 400000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic          refclk,
    input  logic          rst_n,
    hdmi_pll_seq_if.slave bus
);
    localparam int MAX_A =
        (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_C =
        (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CW =
        ($clog2(MAX_C) < 1) ? 1 : $clog2(MAX_C);
    localparam int RW =
        ($clog2(MAX_RETRIES + 1) < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t        st;
    state_t        st_n;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry;
    logic [RW-1:0] retry_n;
    logic [7:0]    loss;
    logic [7:0]    loss_n;
    logic          sync1;
    logic          lock_s;
    logic          clr;
    logic          counting;

    // RUN and FAULT are unbounded, so the counter is frozen there
    assign counting = (st == S_RESET) || (st == S_WAIT_LOCK) ||
                      (st == S_STABLE);

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            st     <= S_RESET;
            cnt    <= '0;
            retry  <= '0;
            loss   <= '0;
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            st     <= st_n;
            retry  <= retry_n;
            loss   <= loss_n;
            sync1  <= bus.pll_locked;
            lock_s <= sync1;
            if (clr) begin
                cnt <= '0;
            end else if (counting) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        st_n    = st;
        retry_n = retry;
        loss_n  = loss;
        clr     = 1'b0;
        if (bus.restart) begin
            st_n    = S_RESET;
            retry_n = '0;
            clr     = 1'b1;
        end else begin
            unique case (st)
                S_RESET: begin
                    if (cnt == RST_LAST) begin
                        st_n = S_WAIT_LOCK;
                        clr  = 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        st_n = S_STABLE;
                        clr  = 1'b1;
                    end else if (cnt == TO_LAST) begin
                        clr = 1'b1;
                        if (retry == RTY_MAX) begin
                            st_n = S_FAULT;
                        end else begin
                            st_n    = S_RESET;
                            retry_n = retry + 1'b1;
                        end
                    end
                end
                S_STABLE: begin
                    // a dropout restarts the wait without charging a retry
                    if (!lock_s) begin
                        st_n = S_WAIT_LOCK;
                        clr  = 1'b1;
                    end else if (cnt == STB_LAST) begin
                        st_n    = S_RUN;
                        retry_n = '0;
                        clr     = 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        st_n = S_RESET;
                        clr  = 1'b1;
                        if (loss != 8'hFF) begin
                            loss_n = loss + 8'd1;
                        end
                    end
                end
                S_FAULT: begin
                    st_n = S_FAULT;
                end
                default: begin
                    st_n = S_RESET;
                    clr  = 1'b1;
                end
            endcase
        end
    end

    assign bus.pll_rst       = (st == S_RESET) || (st == S_FAULT);
    assign bus.clk_ready     = (st == S_RUN);
    assign bus.fault         = (st == S_FAULT);
    assign bus.state         = st;
    assign bus.retry_cnt     = retry;
    assign bus.lock_loss_cnt = loss;
endmodule

// File: tb/tb_hdmi_pll_seq.sv
// Bench for hdmi_pll_seq: directed steps plus random lock/restart
// traffic, every cycle compared against a timeline model.
module tb_hdmi_pll_seq;
    localparam int RST_C = 4;
    localparam int STB_C = 8;
    localparam int TO_C  = 20;
    localparam int MAXR  = 2;
    localparam int RW    = 2;

    logic refclk = 1'b0;
    logic rst_n  = 1'b0;

    hdmi_pll_seq_if #(.RW(RW)) bus ();

    hdmi_pll_seq #(
        .RST_CYCLES     (RST_C),
        .STABLE_CYCLES  (STB_C),
        .TIMEOUT_CYCLES (TO_C),
        .MAX_RETRIES    (MAXR)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    always #5 refclk = ~refclk;

    int n_pass = 0;
    int n_fail = 0;
    int n_tot  = 0;
    int cyc    = 0;

    // model: phase code, cycles spent in phase, retry/loss tallies,
    // and the last two sampled lock values
    int   m_phase = 0;
    int   m_el    = 0;
    int   m_retry = 0;
    int   m_loss  = 0;
    logic m_hist [2];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic ls;
        int   nxt;
        bit   moved;
        if (!rst_n) begin
            m_phase   = 0;
            m_el      = 0;
            m_retry   = 0;
            m_loss    = 0;
            m_hist[0] = 1'b0;
            m_hist[1] = 1'b0;
            return;
        end
        ls        = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = bus.pll_locked;
        nxt   = m_phase;
        moved = bus.restart;
        if (bus.restart) begin
            nxt     = 0;
            m_retry = 0;
        end else if (m_phase == 0) begin
            if (m_el + 1 == RST_C) nxt = 1;
        end else if (m_phase == 1) begin
            if (ls) nxt = 2;
            else if (m_el + 1 == TO_C) begin
                moved = 1;
                if (m_retry == MAXR) nxt = 4;
                else begin
                    nxt = 0;
                    m_retry++;
                end
            end
        end else if (m_phase == 2) begin
            if (!ls) nxt = 1;
            else if (m_el + 1 == STB_C) begin
                nxt     = 3;
                m_retry = 0;
            end
        end else if (m_phase == 3) begin
            if (!ls) begin
                nxt    = 0;
                m_loss = (m_loss < 255) ? m_loss + 1 : 255;
            end
        end
        moved   = moved || (nxt != m_phase);
        m_el    = moved ? 0 : m_el + 1;
        m_phase = nxt;
    endtask

    function automatic logic [15:0] model_outs();
        logic prst;
        prst = (m_phase == 0) || (m_phase == 4);
        return {3'(m_phase), prst, m_phase == 3, m_phase == 4,
                2'(m_retry), 8'(m_loss)};
    endfunction

    task automatic cycle();
        @(posedge refclk);
        model_edge();
        cyc++;
        @(negedge refclk);
        chk("outs",
            {bus.state, bus.pll_rst, bus.clk_ready, bus.fault,
             bus.retry_cnt, bus.lock_loss_cnt},
            model_outs());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.restart = 1'b0;
        cycle();
        chk("rst_state", bus.state, 0);
        chk("rst_pll_rst", bus.pll_rst, 1);
        chk("rst_ready", bus.clk_ready, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_retry", bus.retry_cnt, 0);
        chk("rst_loss", bus.lock_loss_cnt, 0);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic wait_ready(input logic want, input int limit);
        int n = 0;
        while (bus.clk_ready !== want && n < limit) begin
            cycle();
            n++;
        end
        chk("wait_ready", bus.clk_ready, want);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pll_locked = 1'b0;
        bus.restart    = 1'b0;
        m_hist[0] = 1'b0;
        m_hist[1] = 1'b0;
        @(negedge refclk);

        // no lock ever: three attempts then fault
        do_reset();
        repeat (3) cycle();
        chk("t1_rst_hi_3", bus.pll_rst, 1);
        cycle();
        chk("t1_rst_lo_4", bus.pll_rst, 0);
        repeat (19) cycle();
        chk("t1_retry_23", bus.retry_cnt, 0);
        cycle();
        chk("t1_retry_24", bus.retry_cnt, 1);
        chk("t1_rst_24", bus.pll_rst, 1);
        repeat (24) cycle();
        chk("t1_retry_48", bus.retry_cnt, 2);
        repeat (23) cycle();
        chk("t1_fault_71", bus.fault, 0);
        cycle();
        chk("t1_fault_72", bus.fault, 1);
        chk("t1_prst_72", bus.pll_rst, 1);
        chk("t1_state_72", bus.state, 4);
        bus.pll_locked = 1'b1;
        repeat (6) cycle();
        chk("t1_fault_hold", bus.fault, 1);

        // restart out of fault
        bus.restart = 1'b1;
        cycle();
        bus.restart = 1'b0;
        chk("t5_state", bus.state, 0);
        chk("t5_fault", bus.fault, 0);
        chk("t5_retry", bus.retry_cnt, 0);

        // restart on the final timeout edge beats the fault
        bus.pll_locked = 1'b0;
        do_reset();
        repeat (71) cycle();
        bus.restart = 1'b1;
        cycle();
        bus.restart = 1'b0;
        chk("t5b_state", bus.state, 0);
        chk("t5b_retry", bus.retry_cnt, 0);
        chk("t5b_fault", bus.fault, 0);

        // lock arrives 10 cycles after release
        do_reset();
        repeat (10) cycle();
        bus.pll_locked = 1'b1;
        repeat (10) cycle();
        chk("t2_ready_20", bus.clk_ready, 0);
        chk("t2_prst_20", bus.pll_rst, 0);
        cycle();
        chk("t2_ready_21", bus.clk_ready, 1);
        chk("t2_retry_21", bus.retry_cnt, 0);

        // dropout during qualification
        do_reset();
        repeat (10) cycle();
        chk("t3_stable_10", bus.state, 2);
        bus.pll_locked = 1'b0;
        repeat (3) cycle();
        bus.pll_locked = 1'b1;
        chk("t3_wait_13", bus.state, 1);
        chk("t3_retry_13", bus.retry_cnt, 0);
        repeat (10) cycle();
        chk("t3_ready_23", bus.clk_ready, 0);
        cycle();
        chk("t3_ready_24", bus.clk_ready, 1);

        // lock loss in run, then saturate the loss count
        bus.pll_locked = 1'b0;
        repeat (2) cycle();
        chk("t4_ready_26", bus.clk_ready, 1);
        cycle();
        chk("t4_ready_27", bus.clk_ready, 0);
        chk("t4_loss_27", bus.lock_loss_cnt, 1);
        repeat (3) cycle();
        chk("t4_prst_30", bus.pll_rst, 1);
        cycle();
        chk("t4_prst_31", bus.pll_rst, 0);
        for (int i = 1; i < 300; i++) begin
            bus.pll_locked = 1'b1;
            wait_ready(1'b1, 60);
            repeat ($urandom_range(0, 5)) cycle();
            bus.pll_locked = 1'b0;
            repeat ($urandom_range(1, 4)) cycle();
            wait_ready(1'b0, 10);
        end
        chk("t4_loss_sat", bus.lock_loss_cnt, 255);

        // rst_n pulse mid-run
        bus.pll_locked = 1'b1;
        do_reset();
        repeat (20) cycle();
        chk("t6_run", bus.clk_ready, 1);
        do_reset();
        repeat (12) cycle();
        chk("t6_ready_12", bus.clk_ready, 0);
        cycle();
        chk("t6_ready_13", bus.clk_ready, 1);

        // random lock, restart and reset traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0)
                bus.pll_locked = ~bus.pll_locked;
            bus.restart = ($urandom_range(0, 199) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            cycle();
        end
        bus.restart = 1'b0;
        rst_n = 1'b1;
        repeat (4) cycle();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
